// File: rtl/vga_pkg.sv
// Shared framebuffer geometry and arbiter state encodings for the VGA framebuffer scheduler.
package vga_pkg;

    localparam int FB_ROWS   = 16;
    localparam int FB_WORD_W = 32;
    localparam int FB_ADDR_W = 4;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE        = 2'd0;
    localparam state_t S_DISP_WAIT   = 2'd1;
    localparam state_t S_CPU_RD_WAIT = 2'd2;

endpackage

// File: rtl/vga_pix_shift.sv
// Holds the currently displayed row and produces the registered pixel output.
// A CPU write to the displayed row also updates the row and is bypassed into the pixel mux.
module vga_pix_shift
    import vga_pkg::*;
#(
    parameter int WORD_W = FB_WORD_W,
    localparam int XW = $clog2(WORD_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              row_load,
    input  logic [WORD_W-1:0] load_data,
    input  logic              wr_hit,
    input  logic [WORD_W-1:0] wr_data,
    input  logic [XW-1:0]     x_pos,
    input  logic              blank,
    output logic [WORD_W-1:0] row_data,
    output logic              pix
);

    logic [WORD_W-1:0] pix_src;

    // The bypass lets the very next pixel show a coherent write without a refetch.
    always_comb begin
        pix_src = row_data;
        if (wr_hit) begin
            pix_src = wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_data <= '0;
            pix      <= 1'b0;
        end else begin
            if (row_load) begin
                row_data <= load_data;
            end else if (wr_hit) begin
                row_data <= wr_data;
            end
            pix <= blank ? 1'b0 : pix_src[x_pos];
        end
    end

endmodule

// File: rtl/vga_fb_scheduler.sv
// Arbitrates the single-port framebuffer RAM between display row fetches (strict priority)
// and CPU bus accesses, and drives the current pixel bit.
module vga_fb_scheduler
    import vga_pkg::*;
#(
    parameter int ROWS   = FB_ROWS,
    parameter int WORD_W = FB_WORD_W,
    localparam int AW = $clog2(ROWS),
    localparam int XW = $clog2(WORD_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [XW-1:0]     x_pos,
    input  logic [AW-1:0]     y_pos,
    input  logic              blank,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [AW-1:0]     cpu_addr,
    input  logic [WORD_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic [WORD_W-1:0] cpu_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [AW-1:0]     mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              pix,
    output state_t            dbg_state
);

    // CPU handshake: cpu_req (with cpu_we/cpu_addr/cpu_wdata) is held until the cycle in which
    // cpu_ready is high; that cycle completes the access. Writes complete in the grant cycle,
    // reads one cycle after the grant with cpu_rdata valid alongside cpu_ready.

    state_t            state_q, state_d;
    logic              disp_pending_q;
    logic [AW-1:0]     fetched_row_q;
    logic [WORD_W-1:0] rdata_q;
    logic [WORD_W-1:0] row_data;
    logic              pending;
    logic              disp_issue;
    logic              row_load;
    logic              cpu_wr;
    logic              wr_hit;
    logic              en_raw, we_raw, ready_raw;
    logic [AW-1:0]     addr_raw;
    logic [WORD_W-1:0] wdata_raw;

    assign pending = disp_pending_q || (y_pos != fetched_row_q);

    always_comb begin
        state_d    = state_q;
        en_raw     = 1'b0;
        we_raw     = 1'b0;
        addr_raw   = '0;
        wdata_raw  = '0;
        ready_raw  = 1'b0;
        disp_issue = 1'b0;
        row_load   = 1'b0;
        cpu_wr     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pending) begin
                    en_raw     = 1'b1;
                    addr_raw   = y_pos;
                    disp_issue = 1'b1;
                    state_d    = S_DISP_WAIT;
                end else if (cpu_req && cpu_we) begin
                    en_raw    = 1'b1;
                    we_raw    = 1'b1;
                    addr_raw  = cpu_addr;
                    wdata_raw = cpu_wdata;
                    ready_raw = 1'b1;
                    cpu_wr    = 1'b1;
                end else if (cpu_req) begin
                    en_raw   = 1'b1;
                    addr_raw = cpu_addr;
                    state_d  = S_CPU_RD_WAIT;
                end
            end
            S_DISP_WAIT: begin
                row_load = 1'b1;
                state_d  = S_IDLE;
            end
            S_CPU_RD_WAIT: begin
                ready_raw = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are forced quiet while reset is held; the flops are frozen then anyway.
    assign mem_en    = en_raw & rst_n;
    assign mem_we    = we_raw & rst_n;
    assign mem_addr  = rst_n ? addr_raw : '0;
    assign mem_wdata = rst_n ? wdata_raw : '0;
    assign cpu_ready = ready_raw & rst_n;
    assign cpu_rdata = (state_q == S_CPU_RD_WAIT) ? mem_rdata : rdata_q;
    assign dbg_state = state_q;

    assign wr_hit = cpu_wr && (cpu_addr == fetched_row_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            disp_pending_q <= 1'b1;
            fetched_row_q  <= '1;
            rdata_q        <= '0;
        end else begin
            state_q <= state_d;
            if (disp_issue) begin
                disp_pending_q <= 1'b0;
                fetched_row_q  <= y_pos;
            end else if (y_pos != fetched_row_q) begin
                disp_pending_q <= 1'b1;
            end
            if (state_q == S_CPU_RD_WAIT) begin
                rdata_q <= mem_rdata;
            end
        end
    end

    vga_pix_shift #(
        .WORD_W(WORD_W)
    ) u_pix_shift (
        .clk      (clk),
        .rst_n    (rst_n),
        .row_load (row_load),
        .load_data(mem_rdata),
        .wr_hit   (wr_hit),
        .wr_data  (cpu_wdata),
        .x_pos    (x_pos),
        .blank    (blank),
        .row_data (row_data),
        .pix      (pix)
    );

endmodule

// File: tb/tb_vga_fb_scheduler.sv
// Directed bench for vga_fb_scheduler with a behavioural single-port RAM model.
module tb_vga_fb_scheduler;
    import vga_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [4:0]  x_pos;
    logic [3:0]  y_pos;
    logic        blank;
    logic        cpu_req;
    logic        cpu_we;
    logic [3:0]  cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_ready;
    logic [31:0] cpu_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [3:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        pix;
    state_t      dbg_state;

    logic [31:0] ram [16];
    int checks;
    int failures;

    vga_fb_scheduler dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .x_pos    (x_pos),
        .y_pos    (y_pos),
        .blank    (blank),
        .cpu_req  (cpu_req),
        .cpu_we   (cpu_we),
        .cpu_addr (cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready),
        .cpu_rdata(cpu_rdata),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .pix      (pix),
        .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: registered read, data valid the cycle after mem_en & !mem_we
    always @(posedge clk) begin
        if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
        if (mem_en && !mem_we) mem_rdata <= ram[mem_addr];
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        for (int i = 0; i < 16; i++) ram[i] = 32'h0;
        ram[0] = 32'hA5A5_A5A5;
        ram[1] = 32'h0000_0F00;
        ram[5] = 32'h5555_0005;
        mem_rdata = 32'h0;
        rst_n = 1'b0;
        x_pos = 5'd0; y_pos = 4'd0; blank = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 4'd2; cpu_wdata = 32'hDEAD_BEEF;

        // reset state, with a CPU write request held to prove outputs stay quiet
        next(); next();
        #1;
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_cpu_ready", cpu_ready, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_pix", pix, 0);
        chk("rst_state", dbg_state, S_IDLE);
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_wdata = 32'h0; cpu_addr = 4'd0;

        // 1: row 0 fetched right after reset release
        next(); rst_n = 1'b1; #1;
        chk("t1_c1_mem_en", mem_en, 1);
        chk("t1_c1_mem_we", mem_we, 0);
        chk("t1_c1_mem_addr", mem_addr, 0);
        next(); #1;
        chk("t1_c2_state", dbg_state, S_DISP_WAIT);
        chk("t1_c2_mem_en", mem_en, 0);
        next(); #1;
        chk("t1_c3_state", dbg_state, S_IDLE);
        chk("t1_c3_pix_old", pix, 0);
        next(); x_pos = 5'd1; #1;
        chk("t1_pix_x0", pix, 1);
        next(); x_pos = 5'd2; #1;
        chk("t1_pix_x1", pix, 0);
        next(); #1;
        chk("t1_pix_x2", pix, 1);

        // 2: CPU write row 3 while idle, then read it back
        next(); cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 4'd3; cpu_wdata = 32'h0000_0001; #1;
        chk("t2_wr_mem_en", mem_en, 1);
        chk("t2_wr_mem_we", mem_we, 1);
        chk("t2_wr_mem_addr", mem_addr, 3);
        chk("t2_wr_mem_wdata", mem_wdata, 32'h0000_0001);
        chk("t2_wr_ready", cpu_ready, 1);
        next(); cpu_req = 1'b0; cpu_we = 1'b0; cpu_wdata = 32'h0; #1;
        chk("t2_wr_ready_gone", cpu_ready, 0);
        chk("t2_idle_mem_en", mem_en, 0);
        next(); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'd3; #1;
        chk("t2_rd_mem_en", mem_en, 1);
        chk("t2_rd_mem_we", mem_we, 0);
        chk("t2_rd_mem_addr", mem_addr, 3);
        chk("t2_rd_ready_early", cpu_ready, 0);
        next(); #1;
        chk("t2_rd_state", dbg_state, S_CPU_RD_WAIT);
        chk("t2_rd_ready", cpu_ready, 1);
        chk("t2_rd_data", cpu_rdata, 32'h0000_0001);
        cpu_req = 1'b0;
        next(); #1;
        chk("t2_rd_ready_gone", cpu_ready, 0);
        chk("t2_rd_data_held", cpu_rdata, 32'h0000_0001);

        // 3: CPU read row 5 in the same cycle the display moves to row 1
        next(); y_pos = 4'd1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'd5; #1;
        chk("t3_c0_mem_addr", mem_addr, 1);
        chk("t3_c0_mem_en", mem_en, 1);
        chk("t3_c0_mem_we", mem_we, 0);
        chk("t3_c0_ready", cpu_ready, 0);
        next(); #1;
        chk("t3_c1_mem_en", mem_en, 0);
        chk("t3_c1_ready", cpu_ready, 0);
        next(); #1;
        chk("t3_c2_mem_en", mem_en, 1);
        chk("t3_c2_mem_addr", mem_addr, 5);
        chk("t3_c2_ready", cpu_ready, 0);
        next(); #1;
        chk("t3_c3_ready", cpu_ready, 1);
        chk("t3_c3_rdata", cpu_rdata, 32'h5555_0005);
        cpu_req = 1'b0;
        next(); x_pos = 5'd8; #1;
        chk("t3_c4_ready", cpu_ready, 0);
        next(); #1;
        chk("t3_row1_pix_x8", pix, 1);

        // 4: fetch row 7, then a coherent CPU write to it
        next(); y_pos = 4'd7; x_pos = 5'd10; #1;
        chk("t4_fetch_addr", mem_addr, 7);
        next(); next(); next(); #1;
        chk("t4_pix_before", pix, 0);
        next(); cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 4'd7; cpu_wdata = 32'hFFFF_FFFF; #1;
        chk("t4_wr_ready", cpu_ready, 1);
        chk("t4_wr_addr", mem_addr, 7);
        next(); cpu_req = 1'b0; cpu_we = 1'b0; #1;
        chk("t4_pix_after", pix, 1);
        chk("t4_no_refetch_1", mem_en, 0);
        next(); blank = 1'b1; #1;
        chk("t4_no_refetch_2", mem_en, 0);
        chk("t4_pix_hold", pix, 1);

        // 5: blanking forces pix low, release restores it one cycle later
        next(); x_pos = 5'd3; #1;
        chk("t5_blank_1", pix, 0);
        next(); #1;
        chk("t5_blank_2", pix, 0);
        blank = 1'b0;
        next(); #1;
        chk("t5_unblank", pix, 1);

        // 6: reset during CPU_RD_WAIT, display row 0 wins after release
        next(); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'd3; #1;
        chk("t6_rd_issue", mem_en, 1);
        next(); #1;
        chk("t6_in_rd_wait", dbg_state, S_CPU_RD_WAIT);
        rst_n = 1'b0; #1;
        chk("t6_rst_ready", cpu_ready, 0);
        chk("t6_rst_state", dbg_state, S_IDLE);
        chk("t6_rst_rdata", cpu_rdata, 0);
        chk("t6_rst_pix", pix, 0);
        y_pos = 4'd0; cpu_we = 1'b1; cpu_addr = 4'd2; cpu_wdata = 32'h1234_5678;
        next(); next(); rst_n = 1'b1; #1;
        chk("t6_rel_mem_addr", mem_addr, 0);
        chk("t6_rel_mem_en", mem_en, 1);
        chk("t6_rel_mem_we", mem_we, 0);
        chk("t6_rel_ready", cpu_ready, 0);
        next(); #1;
        chk("t6_disp_wait", dbg_state, S_DISP_WAIT);
        chk("t6_wait_ready", cpu_ready, 0);
        next(); #1;
        chk("t6_wr_we", mem_we, 1);
        chk("t6_wr_addr", mem_addr, 2);
        chk("t6_wr_ready", cpu_ready, 1);
        cpu_req = 1'b0; cpu_we = 1'b0;
        next(); #1;
        chk("t6_ready_gone", cpu_ready, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
